// File: rtl/ddr2pix.sv
// rtl/ddr2pix.sv - DDR frame read-back: 3-beat R/G/B bursts unpacked into a 24-bit pixel stream
// Optional PIX_GRAY_EN: pixels become {Y,Y,Y}, Y = (R + 2G + B) >> 2.
module ddr2pix #(
  parameter int H_BLOCKS   = 48,
  parameter int V_LINES    = 1080,
  parameter int LINE_WORDS = H_BLOCKS * 3
) (
  input  logic         ddrclk,
  input  logic         reset,
  input  logic         start,
  output logic         rd_req,
  output logic [24:0]  rd_addr,
  output logic [6:0]   rd_burst,
  input  logic         rd_ack,
  input  logic         rd_valid,
  input  logic [319:0] rd_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [23:0]  pix_data,
  output logic         pix_sol,
  output logic         pix_eol,
  output logic         pix_sof,
  output logic         busy,
  output logic         frame_done,
  output logic         rd_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  localparam logic [5:0]  BLK_LAST  = 6'(H_BLOCKS - 1);
  localparam logic [10:0] LINE_LAST = 11'(V_LINES - 1);
  localparam logic [5:0]  PX_LAST   = 6'd39;

  state_t       state;
  logic [10:0]  line;
  logic [5:0]   blk;
  logic [5:0]   px;
  logic [1:0]   beat;
  logic [319:0] rbuf, gbuf, bbuf;

  logic         last_blk, last_line;
  logic [5:0]   nblk;
  logic [10:0]  nline;

  function automatic logic [24:0] addr_of(input logic [10:0] l, input logic [5:0] b);
    return 25'(l) * 25'(LINE_WORDS) + 25'(b) * 25'd3;
  endfunction

  function automatic logic [23:0] fmt(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef PIX_GRAY_EN
    logic [9:0] y;
    y = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return {3{y[9:2]}};
`else
    return {r, g, b};
`endif
  endfunction

  assign last_blk  = (blk == BLK_LAST);
  assign last_line = (line == LINE_LAST);
  assign nblk      = last_blk ? 6'd0 : blk + 6'd1;
  assign nline     = last_blk ? line + 11'd1 : line;
  assign busy      = (state != IDLE);

  always_ff @(posedge ddrclk) begin
    if (reset) begin
      state      <= IDLE;
      line       <= '0;
      blk        <= '0;
      px         <= '0;
      beat       <= '0;
      rbuf       <= '0;
      gbuf       <= '0;
      bbuf       <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      rd_burst   <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_sol    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_sof    <= 1'b0;
      frame_done <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rd_valid && state != WAIT) rd_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state    <= REQ;
          line     <= '0;
          blk      <= '0;
          px       <= '0;
          beat     <= '0;
          rd_req   <= 1'b1;
          rd_addr  <= '0;
          rd_burst <= 7'd3;
          rd_err   <= rd_valid;
        end
        REQ: if (rd_ack) begin
          state    <= WAIT;
          rd_req   <= 1'b0;
          rd_addr  <= '0;
          rd_burst <= '0;
        end
        WAIT: if (rd_valid) begin
          case (beat)
            2'd0:    rbuf <= rd_data;
            2'd1:    gbuf <= rd_data;
            default: bbuf <= rd_data;
          endcase
          if (beat == 2'd2) begin
            beat  <= '0;
            px    <= '0;
            state <= DRAIN;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        DRAIN: begin
          // The presented pixel always sits in the top byte of each plane buffer.
          if (!pix_valid) begin
            pix_valid <= 1'b1;
            pix_data  <= fmt(rbuf[319:312], gbuf[319:312], bbuf[319:312]);
            pix_sol   <= (blk == 6'd0);
            pix_sof   <= (blk == 6'd0) && (line == 11'd0);
            pix_eol   <= 1'b0;
          end else if (pix_ready) begin
            if (px == PX_LAST) begin
              pix_valid <= 1'b0;
              pix_sol   <= 1'b0;
              pix_sof   <= 1'b0;
              pix_eol   <= 1'b0;
              px        <= '0;
              if (last_blk && last_line) begin
                state      <= IDLE;
                frame_done <= 1'b1;
              end else begin
                blk      <= nblk;
                line     <= nline;
                state    <= REQ;
                rd_req   <= 1'b1;
                rd_addr  <= addr_of(nline, nblk);
                rd_burst <= 7'd3;
              end
            end else begin
              px       <= px + 6'd1;
              rbuf     <= {rbuf[311:0], 8'h00};
              gbuf     <= {gbuf[311:0], 8'h00};
              bbuf     <= {bbuf[311:0], 8'h00};
              pix_data <= fmt(rbuf[311:304], gbuf[311:304], bbuf[311:304]);
              pix_sol  <= 1'b0;
              pix_sof  <= 1'b0;
              pix_eol  <= last_blk && (px == 6'd38);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr2pix.sv
// tb/tb_ddr2pix.sv - self-checking bench for ddr2pix on a reduced 2x3-block frame
// Honours PIX_GRAY_EN in its pixel model.
module tb_ddr2pix;
  localparam int HB = 2;
  localparam int VL = 3;
  localparam int NB = HB * VL;

  logic         ddrclk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         rd_ack = 1'b0;
  logic         rd_valid = 1'b0;
  logic         pix_ready = 1'b0;
  logic [319:0] rd_data = '0;
  logic         rd_req, pix_valid, pix_sol, pix_eol, pix_sof, busy, frame_done, rd_err;
  logic [24:0]  rd_addr;
  logic [6:0]   rd_burst;
  logic [23:0]  pix_data;

  int total = 0;
  int bad = 0;
  logic [319:0] beat_q[$];
  logic [26:0]  exp_q[$];

  ddr2pix #(.H_BLOCKS(HB), .V_LINES(VL)) dut (
    .ddrclk(ddrclk), .reset(reset), .start(start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_burst(rd_burst), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof),
    .busy(busy), .frame_done(frame_done), .rd_err(rd_err)
  );

  always #5 ddrclk = ~ddrclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int r, input int g, input int b);
`ifdef PIX_GRAY_EN
    int y = (r + 2 * g + b) / 4;
    return {3{y[7:0]}};
`else
    return {r[7:0], g[7:0], b[7:0]};
`endif
  endfunction

  // Burst idx covers line idx/HB, block idx%HB; plane bytes go MSB-first.
  task automatic push_burst(input int idx, input int mode);
    logic [319:0] w[3];
    int v[3];
    int ln = idx / HB;
    int bk = idx % HB;
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < 3; p++) begin
        if (idx == 0 && mode == 1) v[p] = k;
        else if (idx == 0 && mode == 2) v[p] = 16 * (p + 1);
        else v[p] = int'($urandom_range(0, 255));
        w[p][319 - 8 * k -: 8] = 8'(v[p]);
      end
      exp_q.push_back({(bk == 0 && k == 0 && ln == 0), (bk == 0 && k == 0),
                       (bk == HB - 1 && k == 39), model_pix(v[0], v[1], v[2])});
    end
    for (int p = 0; p < 3; p++) beat_q.push_back(w[p]);
  endtask

  task automatic run_frame(input int ready_pct, input int mode, input bit poke);
    int bursts = 0, npix = 0, eols = 0, sofs = 0, dones = 0, cyc = 0, req_cnt = 0, ack_dly;
    logic [24:0] last_addr = '0;
    logic [26:0] outv, e, prev_out = '0;
    bit prev_stall = 0;
    ack_dly = int'($urandom_range(0, 3));
    beat_q.delete();
    exp_q.delete();
    start = 1'b1;
    while (dones == 0 && cyc < 20000) begin
      @(negedge ddrclk);
      cyc++;
      start = (poke && cyc == 60);
      rd_ack = 1'b0;
      rd_valid = 1'b0;
      if (cyc == 1) chk("err_clr", rd_err, 0);
      if (frame_done) dones++;
      if (beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rd_valid = 1'b1;
        rd_data = beat_q.pop_front();
      end
      if (rd_req) begin
        req_cnt++;
        chk("rd_addr", rd_addr, 3 * bursts);
        chk("rd_burst", rd_burst, 3);
        if (req_cnt == ack_dly + 1) begin
          rd_ack = 1'b1;
          last_addr = rd_addr;
          push_burst(bursts, mode);
          bursts++;
        end
      end else begin
        if (req_cnt != 0) begin
          chk("req_len", req_cnt, ack_dly + 1);
          req_cnt = 0;
          ack_dly = int'($urandom_range(0, 3));
        end
        chk("idle_addr", {rd_addr, rd_burst}, 0);
      end
      pix_ready = ($urandom_range(0, 99) < ready_pct);
      if (pix_valid) begin
        outv = {pix_sof, pix_sol, pix_eol, pix_data};
        if (prev_stall) chk("stall_hold", outv, prev_out);
        if (pix_ready) begin
          chk("pix_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pix", outv, e);
          end
          if (mode == 1 && npix == 5) chk("pix5", pix_data, 24'h050505);
`ifdef PIX_GRAY_EN
          if (mode == 2 && npix == 0) chk("pix_fmt", pix_data, 24'h202020);
`else
          if (mode == 2 && npix == 0) chk("pix_fmt", pix_data, 24'h102030);
`endif
          npix++;
          eols += pix_eol;
          sofs += pix_sof;
        end
        prev_stall = !pix_ready;
        prev_out = outv;
      end else begin
        prev_stall = 0;
      end
    end
    start = 1'b0;
    pix_ready = 1'b0;
    rd_ack = 1'b0;
    rd_valid = 1'b0;
    chk("frame_end", dones, 1);
    chk("pix_count", npix, NB * 40);
    chk("bursts", bursts, NB);
    chk("last_addr", last_addr, 3 * (NB - 1));
    chk("eol_count", eols, VL);
    chk("sof_count", sofs, 1);
    chk("exp_left", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    chk("err_end", rd_err, 0);
    repeat (4) begin
      @(negedge ddrclk);
      if (frame_done) dones++;
    end
    chk("done_once", dones, 1);
  endtask

  initial begin
    int i;
    reset = 1'b1;
    repeat (3) @(negedge ddrclk);
    chk("rst_req", {rd_req, rd_addr, rd_burst}, 0);
    chk("rst_pix", {pix_valid, pix_data, pix_sol, pix_eol, pix_sof}, 0);
    chk("rst_stat", {busy, frame_done, rd_err}, 0);
    reset = 1'b0;
    @(negedge ddrclk);

    // stray beat while idle is a protocol error and must stick
    rd_valid = 1'b1;
    for (int k = 0; k < 10; k++) rd_data[32 * k +: 32] = $urandom();
    @(negedge ddrclk);
    rd_valid = 1'b0;
    chk("err_set", rd_err, 1);
    @(negedge ddrclk);
    chk("err_sticky", rd_err, 1);

    run_frame(60, 1, 1);
    run_frame(100, 0, 0);

    // reset while draining a block
    start = 1'b1;
    @(negedge ddrclk);
    start = 1'b0;
    for (i = 0; i < 10 && !rd_req; i++) @(negedge ddrclk);
    chk("drn_req", rd_req, 1);
    rd_ack = 1'b1;
    @(negedge ddrclk);
    rd_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rd_valid = 1'b1;
      for (int k = 0; k < 10; k++) rd_data[32 * k +: 32] = $urandom();
      @(negedge ddrclk);
    end
    rd_valid = 1'b0;
    pix_ready = 1'b0;
    for (i = 0; i < 10 && !pix_valid; i++) @(negedge ddrclk);
    chk("drn_valid", pix_valid, 1);
    reset = 1'b1;
    @(negedge ddrclk);
    chk("drn_rst_pix", pix_valid, 0);
    chk("drn_rst_busy", busy, 0);
    reset = 1'b0;
    rd_valid = 1'b1;
    @(negedge ddrclk);
    rd_valid = 1'b0;
    chk("late_beat_err", rd_err, 1);

    run_frame(100, 2, 0);
    run_frame(30, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
